dma_ch_arbiter: RTL and testbench

//   Round-robin command arbiter placed between the DMA channel engines and the shared AXI64 command port
//   of dma_axi64. Selects one requesting, enabled channel and presents its id on a valid/ready command slot.

---
 rtl/dma_ch_arbiter.sv | 118 +++++++++++
 tb/tb_dma_ch_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ch_arbiter.sv
// dma_ch_arbiter: round-robin command arbiter for the DMA channels, with an outstanding-transaction limit.
// Define DMA_ARB_PRIO_EN to enable two-level (high/low priority) arbitration.
module dma_ch_arbiter #(
  parameter int NUM_CH   = 8,
  parameter int MAX_OUTS = 4,
  parameter int CH_W     = $clog2(NUM_CH),
  parameter int OUTS_W   = $clog2(MAX_OUTS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_prio,
  output logic              cmd_valid,
  output logic [CH_W-1:0]   cmd_ch,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  output logic [NUM_CH-1:0] ch_gnt,
  output logic [OUTS_W-1:0] outs_cnt,
  output logic              arb_idle,
  output logic              err_unf
);

  // state | meaning
  // IDLE  | waiting for an eligible request while outs_cnt < MAX_OUTS
  // ISSUE | cmd_valid held with latched cmd_ch until cmd_ready
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state, nxt_state;
  logic [CH_W-1:0]   rr_ptr, nxt_rr_ptr, nxt_cmd_ch, win_ch, rr_idx;
  logic [NUM_CH-1:0] elig, cand, nxt_ch_gnt;
  logic [OUTS_W-1:0] nxt_outs_cnt;
  logic              nxt_cmd_valid, nxt_err_unf, win_found;
  logic              accept, done_ok, room;

  assign elig = ch_req & ch_en;

`ifdef DMA_ARB_PRIO_EN
  assign cand = (|(elig & ch_prio)) ? (elig & ch_prio) : elig;
`else
  logic unused_prio;
  assign unused_prio = ^ch_prio;
  assign cand        = elig;
`endif

  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    rr_idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = rr_ptr + CH_W'(i);
      if (!win_found && cand[rr_idx]) begin
        win_found = 1'b1;
        win_ch    = rr_idx;
      end
    end
  end

  assign room    = (outs_cnt < OUTS_W'(MAX_OUTS));
  assign accept  = (state == ISSUE) && cmd_ready;
  // A completion with nothing outstanding is flagged, never allowed to underflow the count.
  assign done_ok = cmd_done && (outs_cnt != '0);

  always_comb begin
    nxt_state     = state;
    nxt_cmd_valid = cmd_valid;
    nxt_cmd_ch    = cmd_ch;
    nxt_rr_ptr    = rr_ptr;
    nxt_ch_gnt    = '0;
    nxt_err_unf   = err_unf | (cmd_done && (outs_cnt == '0));
    nxt_outs_cnt  = outs_cnt;
    if (accept && !done_ok)
      nxt_outs_cnt = outs_cnt + 1'b1;
    else if (!accept && done_ok)
      nxt_outs_cnt = outs_cnt - 1'b1;
    case (state)
      IDLE: begin
        if (win_found && room) begin
          nxt_state     = ISSUE;
          nxt_cmd_valid = 1'b1;
          nxt_cmd_ch    = win_ch;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          nxt_state          = IDLE;
          nxt_cmd_valid      = 1'b0;
          nxt_ch_gnt[cmd_ch] = 1'b1;
          nxt_rr_ptr         = cmd_ch + 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_ch    <= '0;
      ch_gnt    <= '0;
      outs_cnt  <= '0;
      err_unf   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      state     <= nxt_state;
      cmd_valid <= nxt_cmd_valid;
      cmd_ch    <= nxt_cmd_ch;
      ch_gnt    <= nxt_ch_gnt;
      outs_cnt  <= nxt_outs_cnt;
      err_unf   <= nxt_err_unf;
      rr_ptr    <= nxt_rr_ptr;
    end
  end

  assign arb_idle = (state == IDLE) && !(|elig) && (outs_cnt == '0);

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Self-checking bench for dma_ch_arbiter: expected grant ids are queued when a request is driven
// and checked by a monitor when ch_gnt pulses; scenario tasks check the remaining outputs inline.
module tb_dma_ch_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ch_en = 8'hFF, ch_req = 8'h00, ch_prio = 8'h00, ch_gnt;
  logic       cmd_valid, cmd_ready = 1'b0, cmd_done = 1'b0, arb_idle, err_unf;
  logic [2:0] cmd_ch, outs_cnt;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int mon_exp;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  dma_ch_arbiter #(.NUM_CH(8), .MAX_OUTS(4)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .ch_req(ch_req), .ch_prio(ch_prio),
    .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .ch_gnt(ch_gnt), .outs_cnt(outs_cnt), .arb_idle(arb_idle), .err_unf(err_unf)
  );

  // Scoreboard: every grant pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en && ch_gnt !== 8'h00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_gnt gnt=%h with no grant expected", ch_gnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ch_gnt !== (8'h01 << mon_exp)) begin
          errors++;
          $display("FAIL sb_gnt gnt=%h expected channel %0d", ch_gnt, mon_exp);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0; ch_req = 8'h00; ch_en = 8'hFF; ch_prio = 8'h00; cmd_ready = 1'b0; cmd_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_ch !== 3'd0 || ch_gnt !== 8'h00) begin
      errors++; $display("FAIL reset_cmd valid=%b ch=%0d gnt=%h want 0 0 00", cmd_valid, cmd_ch, ch_gnt);
    end
    checks++;
    if (outs_cnt !== 3'd0 || err_unf !== 1'b0 || arb_idle !== 1'b1) begin
      errors++; $display("FAIL reset_status outs=%0d err=%b idle=%b want 0 0 1", outs_cnt, err_unf, arb_idle);
    end
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    ch_en = 8'hFF; ch_req = 8'h04; cmd_ready = 1'b1; exp_q.push_back(2);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_ch !== 3'd2) begin
      errors++; $display("FAIL single_issue valid=%b ch=%0d want 1 2", cmd_valid, cmd_ch);
    end
    @(negedge clk);
    checks++;
    if (ch_gnt !== 8'h04 || cmd_valid !== 1'b0 || outs_cnt !== 3'd1) begin
      errors++; $display("FAIL single_gnt gnt=%h valid=%b outs=%0d want 04 0 1", ch_gnt, cmd_valid, outs_cnt);
    end
    // rr_ptr now points at 3, so channel 3 beats channel 0
    ch_req = 8'h09; exp_q.push_back(3);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_ch !== 3'd3) begin
      errors++; $display("FAIL single_rr valid=%b ch=%0d want 1 3", cmd_valid, cmd_ch);
    end
    ch_req = 8'h00;
    @(negedge clk);
    checks++;
    if (outs_cnt !== 3'd2) begin
      errors++; $display("FAIL single_outs2 outs=%0d want 2", outs_cnt);
    end
    cmd_done = 1'b1;
    repeat (2) @(negedge clk);
    cmd_done = 1'b0;
    checks++;
    if (outs_cnt !== 3'd0 || err_unf !== 1'b0 || arb_idle !== 1'b1) begin
      errors++; $display("FAIL single_drain outs=%0d err=%b idle=%b want 0 0 1", outs_cnt, err_unf, arb_idle);
    end
  endtask

  task automatic test_fairness();
    int got = 0;
    do_reset();
    ch_req = 8'h81; cmd_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(7);
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (ch_gnt !== 8'h00) begin got++; cmd_done = 1'b1; end
      else cmd_done = 1'b0;
      if (got == 4) ch_req = 8'h00;
    end
    @(negedge clk);
    cmd_done = 1'b0;
    checks++;
    if (got != 4 || outs_cnt !== 3'd0) begin
      errors++; $display("FAIL fair_count grants=%0d outs=%0d want 4 0", got, outs_cnt);
    end
  endtask

  task automatic test_outs_limit();
    int got = 0;
    ch_req = 8'h01; cmd_ready = 1'b1; cmd_done = 1'b0;
    repeat (4) exp_q.push_back(0);
    repeat (20) begin
      @(negedge clk);
      if (ch_gnt !== 8'h00) got++;
    end
    checks++;
    if (got != 4 || cmd_valid !== 1'b0 || outs_cnt !== 3'd4) begin
      errors++; $display("FAIL limit_hold grants=%0d valid=%b outs=%0d want 4 0 4", got, cmd_valid, outs_cnt);
    end
    exp_q.push_back(0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || outs_cnt !== 3'd3) begin
      errors++; $display("FAIL limit_done valid=%b outs=%0d want 0 3", cmd_valid, outs_cnt);
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++; $display("FAIL limit_reissue valid=%b want 1", cmd_valid);
    end
    @(negedge clk);
    checks++;
    if (ch_gnt !== 8'h01 || outs_cnt !== 3'd4) begin
      errors++; $display("FAIL limit_gnt5 gnt=%h outs=%0d want 01 4", ch_gnt, outs_cnt);
    end
    ch_req = 8'h00;
    cmd_done = 1'b1;
    repeat (2) @(negedge clk);
    cmd_done = 1'b0;
  endtask

  task automatic test_accept_done();
    ch_req = 8'h01; exp_q.push_back(0);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || outs_cnt !== 3'd2) begin
      errors++; $display("FAIL ad_setup valid=%b outs=%0d want 1 2", cmd_valid, outs_cnt);
    end
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0; ch_req = 8'h00;
    checks++;
    if (outs_cnt !== 3'd2 || ch_gnt !== 8'h01) begin
      errors++; $display("FAIL ad_same_cycle outs=%0d gnt=%h want 2 01", outs_cnt, ch_gnt);
    end
    cmd_done = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs_cnt !== 3'd0 || err_unf !== 1'b0) begin
      errors++; $display("FAIL ad_drain outs=%0d err=%b want 0 0", outs_cnt, err_unf);
    end
    @(negedge clk);
    cmd_done = 1'b0;
    checks++;
    if (outs_cnt !== 3'd0 || err_unf !== 1'b1) begin
      errors++; $display("FAIL ad_underflow outs=%0d err=%b want 0 1", outs_cnt, err_unf);
    end
    @(negedge clk);
    checks++;
    if (err_unf !== 1'b1) begin
      errors++; $display("FAIL ad_sticky err=%b want 1", err_unf);
    end
  endtask

  task automatic test_disable_issue();
    do_reset();
    checks++;
    if (err_unf !== 1'b0) begin
      errors++; $display("FAIL dis_err_clear err=%b want 0", err_unf);
    end
    cmd_ready = 1'b0; ch_req = 8'h08; exp_q.push_back(3);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_ch !== 3'd3) begin
      errors++; $display("FAIL dis_issue valid=%b ch=%0d want 1 3", cmd_valid, cmd_ch);
    end
    ch_en = 8'hF7; ch_req = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_ch !== 3'd3) begin
      errors++; $display("FAIL dis_hold valid=%b ch=%0d want 1 3", cmd_valid, cmd_ch);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ch_gnt !== 8'h08 || cmd_valid !== 1'b0 || outs_cnt !== 3'd1) begin
      errors++; $display("FAIL dis_gnt gnt=%h valid=%b outs=%0d want 08 0 1", ch_gnt, cmd_valid, outs_cnt);
    end
    ch_en = 8'hFF; cmd_ready = 1'b0; ch_req = 8'h10;
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_ch !== 3'd4) begin
      errors++; $display("FAIL rst_issue valid=%b ch=%0d want 1 4", cmd_valid, cmd_ch);
    end
    // Reset together with cmd_ready must not produce a grant.
    reset = 1'b0; cmd_ready = 1'b1; ch_req = 8'h00;
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_ch !== 3'd0 || ch_gnt !== 8'h00 || outs_cnt !== 3'd0 || arb_idle !== 1'b1) begin
      errors++; $display("FAIL rst_mid valid=%b ch=%0d gnt=%h outs=%0d idle=%b want 0 0 00 0 1",
                         cmd_valid, cmd_ch, ch_gnt, outs_cnt, arb_idle);
    end
    reset = 1'b1; cmd_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_prio();
    int exp_ch;
`ifdef DMA_ARB_PRIO_EN
    exp_ch = 3;
`else
    exp_ch = 0;
`endif
    do_reset();
    ch_req = 8'h0F; ch_prio = 8'h08; cmd_ready = 1'b1; exp_q.push_back(exp_ch);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_ch !== 3'(exp_ch)) begin
      errors++; $display("FAIL prio_first valid=%b ch=%0d want 1 %0d", cmd_valid, cmd_ch, exp_ch);
    end
    ch_req = 8'h00; ch_prio = 8'h00;
    @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    checks++;
    if (outs_cnt !== 3'd0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL prio_end outs=%0d valid=%b want 0 0", outs_cnt, cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_outs_limit();
    test_accept_done();
    test_disable_issue();
    test_prio();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover pending=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
